switch_debounce: RTL



---
 rtl/switch_debounce.sv | 131 +++++++++++++
 1 files changed

// File: rtl/switch_debounce.sv
// Synchronizer and per-bit debouncer for the board DIP switches.
// Define SWITCH_DEBOUNCE_EDGE_CAPTURE_EN for sticky edge flags and irq.
module switch_debounce #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
`ifdef SWITCH_DEBOUNCE_EDGE_CAPTURE_EN
    ,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_capture,
    output logic             irq
`endif
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] flip;

    assign sync_q = sync_r[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= '0;
            end
        end else begin
            sync_r[0] <= sw_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        state_t          state_q;
        state_t          state_d;
        logic [CW-1:0]   cnt_q;
        logic [CW-1:0]   cnt_d;
        logic            flip_b;

        assign flip[i] = flip_b;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            flip_b  = 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (sync_q[i] != sw_stable[i]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            flip_b = 1'b1;
                        end else begin
                            cnt_d   = CNT_ONE;
                            state_d = COUNT;
                        end
                    end
                end
                COUNT: begin
                    // a return to the accepted level is a bounce
                    if (sync_q[i] == sw_stable[i]) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        flip_b  = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_stable <= '0;
            sw_rise   <= '0;
            sw_fall   <= '0;
        end else begin
            sw_stable <= sw_stable ^ flip;
            sw_rise   <= flip & ~sw_stable;
            sw_fall   <= flip & sw_stable;
        end
    end

`ifdef SWITCH_DEBOUNCE_EDGE_CAPTURE_EN
    // set beats clear when both land on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~edge_clear) | sw_rise | sw_fall;
        end
    end

    assign irq = |edge_capture;
`endif

endmodule
